// File: rtl/bmc_soft_pipe.sv
// rtl/bmc_soft_pipe.sv - pipelined soft-decision branch-metric unit with optional min-normalisation
module bmc_soft_pipe #(
  parameter int  N_OUT  = 2,
  parameter int  SOFT_W = 3,
  parameter int  NORM   = 0,
  localparam int BM_W   = SOFT_W + $clog2(N_OUT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_OUT*SOFT_W-1:0]       rx_soft,
  input  logic [N_OUT-1:0]              rx_erase,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(2**N_OUT)*BM_W-1:0]    bm_flat,
  output logic [N_OUT-1:0]              bm_min_idx
);

  localparam int NH = 2**N_OUT;
  localparam logic [SOFT_W-1:0] SOFT_MAX = {SOFT_W{1'b1}};

  logic s1_valid, s2_valid, s3_valid;
  logic s1_en, s2_en, s3_en;

  logic [N_OUT-1:0][SOFT_W-1:0] s1_d0, s1_d1;
  logic [N_OUT-1:0]             s1_erase;
  logic [NH-1:0][BM_W-1:0]      metric_c;
  logic [NH-1:0][BM_W-1:0]      s2_metric;
  logic [BM_W-1:0]              min_val;
  logic [N_OUT-1:0]             min_idx;
  logic [NH-1:0][BM_W-1:0]      norm_c;
  logic [NH-1:0][BM_W-1:0]      s3_metric;
  logic [N_OUT-1:0]             s3_min_idx;

  // A stage may load when empty or when its successor takes its content this cycle.
  assign s3_en     = ~s3_valid | out_ready;
  assign s2_en     = ~s2_valid | s3_en;
  assign s1_en     = ~s1_valid | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s3_valid;
  assign bm_flat   = s3_metric;
  assign bm_min_idx = s3_min_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (s1_en) s1_valid <= in_valid;
      if (s2_en) s2_valid <= s1_valid;
      if (s3_en) s3_valid <= s2_valid;
    end
  end

  // S1: distances of each soft value to the ideal '0' and ideal '1' points.
  always_ff @(posedge clk) begin
    if (s1_en && in_valid) begin
      for (int k = 0; k < N_OUT; k++) begin
        s1_d0[k] <= rx_erase[k] ? '0 : rx_soft[k*SOFT_W +: SOFT_W];
        s1_d1[k] <= rx_erase[k] ? '0 : SOFT_MAX - rx_soft[k*SOFT_W +: SOFT_W];
      end
      s1_erase <= rx_erase;
    end
  end

  always_comb begin
    metric_c = '0;
    for (int h = 0; h < NH; h++) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (!s1_erase[k]) begin
          metric_c[h] = metric_c[h] + BM_W'(h[k] ? s1_d1[k] : s1_d0[k]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s2_en && s1_valid) begin
      s2_metric <= metric_c;
    end
  end

  // Strict less-than keeps the lowest hypothesis index on ties.
  always_comb begin
    min_val = s2_metric[0];
    min_idx = '0;
    for (int h = 1; h < NH; h++) begin
      if (s2_metric[h] < min_val) begin
        min_val = s2_metric[h];
        min_idx = N_OUT'(h);
      end
    end
  end

  always_comb begin
    norm_c = '0;
    for (int h = 0; h < NH; h++) begin
      if (NORM != 0) begin
        norm_c[h] = s2_metric[h] - min_val;
      end else begin
        norm_c[h] = s2_metric[h];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_metric  <= '0;
      s3_min_idx <= '0;
    end else if (s3_en && s2_valid) begin
      s3_metric  <= norm_c;
      s3_min_idx <= min_idx;
    end
  end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// tb/tb_bmc_soft_pipe.sv - randomized and directed bench for bmc_soft_pipe against a distance model
module tb_bmc_soft_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [5:0]  rx_soft;
  logic [1:0]  rx_erase, rx_hard;
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [15:0] bm_a, bm_b;
  logic [7:0]  bm_c;
  logic [1:0]  idx_a, idx_b, idx_c;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  typedef struct {
    int         x0;
    int         x1;
    logic [1:0] er;
    logic [1:0] hb;
  } sym_t;

  sym_t        q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] snap_bm;
  logic [1:0]  snap_idx;

  always #5 clk = ~clk;

  bmc_soft_pipe #(.N_OUT(2), .SOFT_W(3), .NORM(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .rx_soft(rx_soft), .rx_erase(rx_erase), .out_valid(out_valid_a),
    .out_ready(out_ready), .bm_flat(bm_a), .bm_min_idx(idx_a)
  );

  bmc_soft_pipe #(.N_OUT(2), .SOFT_W(3), .NORM(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .rx_soft(rx_soft), .rx_erase(rx_erase), .out_valid(out_valid_b),
    .out_ready(out_ready), .bm_flat(bm_b), .bm_min_idx(idx_b)
  );

  bmc_soft_pipe #(.N_OUT(2), .SOFT_W(1), .NORM(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .rx_soft(rx_hard), .rx_erase(rx_erase), .out_valid(out_valid_c),
    .out_ready(out_ready), .bm_flat(bm_c), .bm_min_idx(idx_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Metric = distance of the received point to the ideal point of each hypothesis.
  function automatic void ref_bm(input int sw, input int norm, input int x0, input int x1,
                                 input logic [1:0] er, output int m[4], output int idx);
    int top, xv, mn;
    top = (1 << sw) - 1;
    for (int h = 0; h < 4; h++) begin
      m[h] = 0;
      for (int k = 0; k < 2; k++) begin
        xv = (k == 0) ? x0 : x1;
        if (!er[k]) m[h] += (((h >> k) & 1) != 0) ? (top - xv) : xv;
      end
    end
    mn = m[0];
    idx = 0;
    for (int h = 1; h < 4; h++) begin
      if (m[h] < mn) begin
        mn = m[h];
        idx = h;
      end
    end
    if (norm != 0) for (int h = 0; h < 4; h++) m[h] -= mn;
  endfunction

  task automatic chk_bm(input string tag, input logic [15:0] got, input int w, input int exp[4]);
    int v;
    for (int h = 0; h < 4; h++) begin
      v = int'(got >> (h * w)) & ((1 << w) - 1);
      check_eq($sformatf("%s_h%0d", tag, h), v, exp[h]);
    end
  endtask

  task automatic chk_const(input string tag, input logic [15:0] got, input int w,
                           input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk_bm(tag, got, w, e);
  endtask

  task automatic compare_all(input sym_t s);
    int m[4];
    int idx;
    ref_bm(3, 0, s.x0, s.x1, s.er, m, idx);
    chk_bm("bm_a", bm_a, 4, m);
    check_eq("idx_a", idx_a, idx);
    ref_bm(3, 1, s.x0, s.x1, s.er, m, idx);
    chk_bm("bm_b", bm_b, 4, m);
    check_eq("idx_b", idx_b, idx);
    ref_bm(1, 0, int'(s.hb[0]), int'(s.hb[1]), s.er, m, idx);
    chk_bm("bm_c", {8'd0, bm_c}, 2, m);
    check_eq("idx_c", idx_c, idx);
    check_eq("valid_bc", {out_valid_b, out_valid_c}, 2'b11);
  endtask

  always @(negedge clk) begin : mon
    sym_t s;
    if (rst) begin
      q.delete();
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", out_valid_a, 1);
        check_eq("hold_bm", bm_a, snap_bm);
        check_eq("hold_idx", idx_a, snap_idx);
      end
      prev_stall <= out_valid_a && !out_ready;
      snap_bm    <= bm_a;
      snap_idx   <= idx_a;
      if (out_valid_a && out_ready) begin
        n_out <= n_out + 1;
        check_eq("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          s = q.pop_front();
          compare_all(s);
        end
      end
      if (in_valid && in_ready_a) begin
        s.x0 = int'(rx_soft[2:0]);
        s.x1 = int'(rx_soft[5:3]);
        s.er = rx_erase;
        s.hb = rx_hard;
        q.push_back(s);
      end
    end
  end

  task automatic set_inputs(input sym_t s);
    rx_soft  = {3'(s.x1), 3'(s.x0)};
    rx_erase = s.er;
    rx_hard  = s.hb;
  endtask

  task automatic drive(input int x0, input int x1, input logic [1:0] er, input logic [1:0] hb);
    sym_t s;
    s.x0 = x0; s.x1 = x1; s.er = er; s.hb = hb;
    set_inputs(s);
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk);
      #1;
    end
    if (!ok) check_eq("accept_timeout", ok, 1);
  endtask

  task automatic wait_out();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (out_valid_a) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("out_timeout", ok, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    check_eq({tag, "_out_valid"}, out_valid_a, 0);
    check_eq({tag, "_bm"}, bm_a, 0);
    check_eq({tag, "_idx"}, idx_a, 0);
    check_eq({tag, "_in_ready"}, in_ready_a, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    sym_t bp[5];
    int   acc, base;
    bit   took;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    rx_soft = '0; rx_erase = '0; rx_hard = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state("reset");

    // Strong {7,0} symbol: latency and reference metrics.
    drive(0, 7, 2'b00, 2'b01);
    wait_accept();
    in_valid = 1'b0;
    check_eq("lat_1", out_valid_a, 0);
    @(posedge clk); #1;
    check_eq("lat_2", out_valid_a, 0);
    @(posedge clk); #1;
    check_eq("lat_3", out_valid_a, 1);
    chk_const("t1_a", bm_a, 4, 7, 14, 0, 7);
    check_eq("t1_idx_a", idx_a, 2);
    chk_const("t1_c", {8'd0, bm_c}, 2, 1, 0, 2, 1);
    check_eq("t1_idx_c", idx_c, 1);

    drive(3, 4, 2'b00, 2'b10);
    wait_accept();
    in_valid = 1'b0;
    wait_out();
    chk_const("t2_a", bm_a, 4, 7, 8, 6, 7);
    check_eq("t2_idx_a", idx_a, 2);
    chk_const("t2_b", bm_b, 4, 1, 2, 0, 1);
    check_eq("t2_idx_b", idx_b, 2);

    drive(0, 7, 2'b10, 2'b11);
    wait_accept();
    in_valid = 1'b0;
    wait_out();
    chk_const("t3_a", bm_a, 4, 0, 7, 0, 7);
    check_eq("t3_idx_a", idx_a, 0);

    drive(5, 2, 2'b11, 2'b01);
    wait_accept();
    in_valid = 1'b0;
    wait_out();
    chk_const("t4_a", bm_a, 4, 0, 0, 0, 0);
    chk_const("t4_b", bm_b, 4, 0, 0, 0, 0);
    check_eq("t4_idx_a", idx_a, 0);
    @(posedge clk); #1;

    // Backpressure: five symbols offered while the consumer stalls.
    for (int i = 0; i < 5; i++) begin
      bp[i].x0 = i + 1; bp[i].x1 = 6 - i; bp[i].er = 2'b00; bp[i].hb = 2'(i);
    end
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (in_ready_a) set_inputs(bp[acc]);
      else rx_soft = 6'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      took = in_ready_a;
      @(posedge clk); #1;
      if (took) acc++;
    end
    check_eq("bp_accepted_stalled", acc, 3);
    check_eq("bp_in_ready_low", in_ready_a, 0);
    out_ready = 1'b1;
    base = n_out;
    for (int c = 0; c < 5; c++) begin
      if (acc < 5) begin
        set_inputs(bp[acc]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      took = in_valid && in_ready_a;
      @(posedge clk); #1;
      if (took) acc++;
    end
    in_valid = 1'b0;
    check_eq("bp_accepted_all", acc, 5);
    check_eq("bp_out_count", n_out - base, 5);
    check_eq("bp_drained", q.size(), 0);

    // Reset with two symbols in flight.
    drive(1, 6, 2'b00, 2'b00);
    wait_accept();
    drive(2, 5, 2'b01, 2'b11);
    wait_accept();
    rst = 1'b1;
    rx_soft = 6'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk_reset_state("midrst");
    base = n_out;
    repeat (6) @(posedge clk);
    #1;
    check_eq("midrst_no_ghost", n_out - base, 0);
    drive(6, 1, 2'b00, 2'b10);
    wait_accept();
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_lat_2", out_valid_a, 0);
    @(posedge clk); #1;
    check_eq("midrst_lat_3", out_valid_a, 1);
    @(posedge clk); #1;
    check_eq("midrst_one_out", n_out - base, 1);

    // Random traffic with random stalls and erasures.
    base = n_out;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      rx_soft   = 6'($urandom);
      rx_erase  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      rx_hard   = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("rand_drained", q.size(), 0);
    check_eq("rand_progress", (n_out - base) > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
